// File: rtl/tinymips_boot_ctrl_pkg.sv
// Shared definitions for the TinyMIPS boot/run sequencer.
// The state encoding is visible on state_o, so these values are fixed.
package tinymips_boot_ctrl_pkg;

    localparam int DEF_SIZE  = 8;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_HOLD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } boot_state_e;

endpackage

// File: rtl/tinymips_boot_ctrl_ram_mux.sv
// Single-port RAM arbitration: host loader side or TinyMIPS core side.
// Purely combinational; the select comes straight from the controller state register.
module tinymips_ram_mux #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 16
) (
    input  logic             sel_cpu,
    input  logic             host_we,
    input  logic [SIZE-1:0]  host_addr,
    input  logic [WIDTH-1:0] host_data,
    input  logic             cpu_we,
    input  logic [SIZE-1:0]  cpu_addr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             ram_we,
    output logic [SIZE-1:0]  ram_addr,
    output logic [WIDTH-1:0] ram_data
);

    always_comb begin
        if (sel_cpu) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end else begin
            // Host data only reaches the bus on an accepted handshake.
            ram_we   = host_we;
            ram_addr = host_addr;
            ram_data = host_we ? host_data : '0;
        end
    end

endmodule

// File: rtl/tinymips_boot_ctrl.sv
// Boot/run sequencer: streams a program image into RAM with the core held in reset,
// then hands the RAM port to the core for a bounded number of cycles.
module tinymips_boot_ctrl
    import tinymips_boot_ctrl_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int DEPTH      = 2**SIZE,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RST_HOLD   = 4,
    parameter int RUN_CYCLES = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic             halt,
    input  logic             rearm,
    input  logic             cpu_wrEn,
    input  logic [SIZE-1:0]  cpu_addr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_rst,
    output logic             ram_wrEn,
    output logic [SIZE-1:0]  ram_addr,
    output logic [WIDTH-1:0] ram_data,
    output logic [1:0]       state_o,
    output logic [SIZE:0]    load_count,
    output logic [15:0]      cycles,
    output logic             done
);

    localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [SIZE-1:0] PTR_LAST  = SIZE'(DEPTH - 1);
    localparam logic [15:0]     RUN_LAST  = 16'(RUN_CYCLES - 1);

    boot_state_e       state_q, state_d;
    logic [SIZE-1:0]   ptr_q, ptr_d;
    logic [SIZE:0]     load_count_q, load_count_d;
    logic [15:0]       cycles_q, cycles_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              handshake;
    logic              sel_cpu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            load_count_q <= '0;
            cycles_q     <= '0;
            hold_cnt_q   <= '0;
            cpu_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            cycles_q     <= cycles_d;
            hold_cnt_q   <= hold_cnt_d;
            cpu_rst_q    <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (handshake && (ld_last || ptr_q == PTR_LAST)) state_d = ST_HOLD;
            ST_HOLD: if (hold_cnt_q == HOLD_LAST)                     state_d = ST_RUN;
            ST_RUN:  if (halt || cycles_q == RUN_LAST)                state_d = ST_DONE;
            ST_DONE: if (rearm)                                       state_d = ST_LOAD;
            default:                                                  state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        cycles_d     = cycles_q;
        hold_cnt_d   = hold_cnt_q;
        unique case (state_q)
            ST_LOAD: begin
                if (handshake) begin
                    load_count_d = load_count_q + 1'b1;
                    // Pointer parks on the last word rather than wrapping.
                    if (ptr_q != PTR_LAST) ptr_d = ptr_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    cycles_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: cycles_d = cycles_q + 1'b1;
            ST_DONE: begin
                if (rearm) begin
                    ptr_d        = '0;
                    load_count_d = '0;
                    cycles_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // Core reset is registered from the next state so it never glitches.
    always_comb begin
        cpu_rst_d = (state_d != ST_RUN);
    end

    always_comb begin
        ld_ready  = (state_q == ST_LOAD);
        done      = (state_q == ST_DONE);
        sel_cpu   = (state_q == ST_RUN);
        handshake = ld_valid & ld_ready;
    end

    tinymips_ram_mux #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_ram_mux (
        .sel_cpu   (sel_cpu),
        .host_we   (handshake),
        .host_addr (ptr_q),
        .host_data (ld_data),
        .cpu_we    (cpu_wrEn),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .ram_we    (ram_wrEn),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    assign cpu_rst    = cpu_rst_q;
    assign state_o    = state_q;
    assign load_count = load_count_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_tinymips_boot_ctrl.sv
// Randomized bench for tinymips_boot_ctrl with a behavioural RAM and an
// expected-image model derived from load/run/done scenario rules.
module tb_tinymips_boot_ctrl;

    localparam int SIZE       = 8;
    localparam int WIDTH      = 16;
    localparam int DEPTH      = 256;
    localparam int RST_HOLD   = 4;
    localparam int RUN_CYCLES = 600;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid, ld_last, ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic             halt, rearm;
    logic             cpu_wrEn;
    logic [SIZE-1:0]  cpu_addr;
    logic [WIDTH-1:0] cpu_data;
    logic             cpu_rst, ram_wrEn;
    logic [SIZE-1:0]  ram_addr;
    logic [WIDTH-1:0] ram_data;
    logic [1:0]       state_o;
    logic [SIZE:0]    load_count;
    logic [15:0]      cycles;
    logic             done;

    always #5 clk = ~clk;

    tinymips_boot_ctrl #(
        .SIZE       (SIZE),
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .RST_HOLD   (RST_HOLD),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .halt       (halt),
        .rearm      (rearm),
        .cpu_wrEn   (cpu_wrEn),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_rst    (cpu_rst),
        .ram_wrEn   (ram_wrEn),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .state_o    (state_o),
        .load_count (load_count),
        .cycles     (cycles),
        .done       (done)
    );

    // Stand-in for blram: synchronous write port.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    int               wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_wrEn) begin
            mem[ram_addr] <= ram_data;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    logic [WIDTH-1:0] exp_mem [0:DEPTH-1];
    logic [WIDTH-1:0] img     [0:DEPTH+43];
    logic [WIDTH-1:0] prog    [0:5] = '{16'h7201, 16'h7400, 16'h7606, 16'h0488, 16'h1241, 16'h92FE};
    int errors = 0;
    int checks = 0;
    int exp_lc = 0;
    int exp_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rand_cpu(input bit force_we);
        cpu_wrEn = force_we ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom);
        cpu_data = 16'($urandom);
    endtask

    task automatic mem_check(input string tag);
        int d = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) d++;
        check_eq(tag, d, 0);
    endtask

    task automatic rand_img(input int n);
        for (int i = 0; i < n; i++) img[i] = 16'($urandom);
    endtask

    // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random gaps
    task automatic load_image(input int n, input int mode);
        int acc  = (n > DEPTH) ? DEPTH : n;
        int i    = 0;
        int g    = 0;
        int le   = 0;
        int he   = 0;
        int h    = 0;
        int base = wr_cnt;
        bit v;
        while (i < acc && g < 4000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_data  = v ? img[i] : 16'($urandom);
            ld_last  = v && (n <= DEPTH) && (i == n - 1);
            halt     = 1'($urandom_range(0, 1));
            rearm    = 1'($urandom_range(0, 1));
            rand_cpu(1'b0);
            #1;
            if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) le++;
            if (v) begin
                if (ram_wrEn !== 1'b1 || ram_addr !== 8'(i) || ram_data !== img[i]) le++;
            end else if (ram_wrEn !== 1'b0 || ram_addr !== 8'(i)) le++;
            @(posedge clk); #1;
            if (v) begin
                exp_mem[i] = img[i];
                i++;
            end
            g++;
            if (state_o !== ((i < acc) ? 2'b00 : 2'b01)) le++;
        end
        check_eq("load_accepted", i, acc);
        check_eq("load_stream", le, 0);
        check_eq("load_count", load_count, acc);
        exp_lc = acc;
        while (state_o == 2'b01 && h < 50) begin
            @(negedge clk);
            ld_valid = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ld_data  = (h == 0 && n > DEPTH) ? img[DEPTH] : 16'($urandom);
            ld_last  = 1'($urandom_range(0, 1));
            halt     = 1'($urandom_range(0, 1));
            rearm    = 1'($urandom_range(0, 1));
            rand_cpu(1'b1);
            #1;
            if (ld_ready !== 1'b0 || ram_wrEn !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) he++;
            @(posedge clk); #1;
            h++;
        end
        check_eq("hold_len", h, RST_HOLD);
        check_eq("hold_guard", he, 0);
        check_eq("load_writes", wr_cnt - base, acc);
        check_eq("run_entry_state", state_o, 2'b10);
        check_eq("run_entry_cycles", cycles, 0);
        check_eq("run_entry_cpu_rst", cpu_rst, 1'b0);
        mem_check("mem_after_load");
    endtask

    task automatic run_phase(input int halt_at, input int reset_at);
        int k    = 0;
        int me   = 0;
        int ce   = 0;
        int nw   = 0;
        int base = wr_cnt;
        int exp;
        bit fin  = 1'b0;
        bit rs   = 1'b0;
        while (!fin && !rs && k < 1000) begin
            @(negedge clk);
            k++;
            rand_cpu(1'b0);
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 16'($urandom);
            ld_last  = 1'($urandom_range(0, 1));
            rearm    = 1'($urandom_range(0, 1));
            halt     = (k == halt_at);
            if (k == reset_at) begin
                ld_valid = 1'b0;
                rst = 1'b0;
                #1;
                check_eq("arst_cpu_rst", cpu_rst, 1'b1);
                check_eq("arst_state", state_o, 2'b00);
                check_eq("arst_cycles", cycles, 0);
                check_eq("arst_load_count", load_count, 0);
                check_eq("arst_ram_wrEn", ram_wrEn, 1'b0);
                check_eq("arst_ld_ready", ld_ready, 1'b1);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                rs  = 1'b1;
            end else begin
                #1;
                if (cpu_rst !== 1'b0 || ram_wrEn !== cpu_wrEn || ram_addr !== cpu_addr ||
                    ram_data !== cpu_data) me++;
                if (cycles !== 16'(k - 1)) ce++;
                if (cpu_wrEn) begin
                    exp_mem[cpu_addr] = cpu_data;
                    nw++;
                end
                @(posedge clk); #1;
                if (state_o == 2'b11) fin = 1'b1;
                else if (state_o !== 2'b10) ce++;
            end
        end
        halt = 1'b0;
        check_eq("run_mux", me, 0);
        check_eq("run_cycle_track", ce, 0);
        if (rs) begin
            exp_lc  = 0;
            exp_cyc = 0;
            mem_check("mem_after_arst");
        end else begin
            exp = (halt_at >= 1 && halt_at < RUN_CYCLES) ? halt_at : RUN_CYCLES;
            exp_cyc = exp;
            check_eq("run_len", k, exp);
            check_eq("run_cycles", cycles, exp);
            check_eq("run_done", done, 1'b1);
            check_eq("run_exit_cpu_rst", cpu_rst, 1'b1);
            check_eq("run_writes", wr_cnt - base, nw);
            mem_check("mem_after_run");
        end
    endtask

    task automatic done_phase(input bit do_rearm);
        int de = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = 16'($urandom);
            halt     = 1'($urandom_range(0, 1));
            rearm    = 1'b0;
            rand_cpu(1'b1);
            #1;
            if (ram_wrEn !== 1'b0 || done !== 1'b1 || ld_ready !== 1'b0 || cpu_rst !== 1'b1) de++;
            @(posedge clk); #1;
            if (state_o !== 2'b11 || cycles !== 16'(exp_cyc) || load_count !== 9'(exp_lc)) de++;
        end
        check_eq("done_frozen", de, 0);
        mem_check("mem_in_done");
        if (do_rearm) begin
            @(negedge clk);
            ld_valid = 1'b0;
            cpu_wrEn = 1'b0;
            halt     = 1'b0;
            rearm    = 1'b1;
            @(posedge clk); #1;
            rearm = 1'b0;
            check_eq("rearm_state", state_o, 2'b00);
            check_eq("rearm_load_count", load_count, 0);
            check_eq("rearm_cycles", cycles, 0);
            check_eq("rearm_done", done, 1'b0);
            check_eq("rearm_cpu_rst", cpu_rst, 1'b1);
            check_eq("rearm_ld_ready", ld_ready, 1'b1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        halt = 1'b0; rearm = 1'b0;
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", state_o, 2'b00);
        check_eq("rst_cpu_rst", cpu_rst, 1'b1);
        check_eq("rst_ram_wrEn", ram_wrEn, 1'b0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_data", ram_data, 0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ld_ready", ld_ready, 1'b1);
        check_eq("rst_load_count", load_count, 0);
        check_eq("rst_cycles", cycles, 0);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) img[i] = prog[i];
        load_image(6, 0);
        check_eq("prog_mem0", mem[0], 16'h7201);
        check_eq("prog_mem5", mem[5], 16'h92FE);
        run_phase(0, 0);
        done_phase(1'b1);

        load_image(6, 1);
        run_phase(10, 0);
        done_phase(1'b1);

        rand_img(DEPTH + 1);
        load_image(DEPTH + 1, 2);
        check_eq("ovf_mem255", mem[DEPTH-1], img[DEPTH-1]);
        run_phase(RUN_CYCLES, 0);
        done_phase(1'b1);

        rand_img(2);
        load_image(2, 2);
        run_phase($urandom_range(1, 40), 0);
        done_phase(1'b1);

        n = $urandom_range(1, 20);
        rand_img(n);
        load_image(n, 2);
        run_phase(0, $urandom_range(2, 50));

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 40);
            rand_img(n);
            load_image(n, 2);
            run_phase($urandom_range(1, 700), 0);
            done_phase(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
